// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: mode encoding, control/TERC4/guard characters (q_out bit order)
// and the bit-reverse helper; used by both the transmit encoder and the receive decoder.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTL   = 2'd0,
    MODE_VIDEO = 2'd1,
    MODE_DATA  = 2'd2,
    MODE_GUARD = 2'd3
  } tmds_mode_e;

  localparam logic [9:0] CTL_QOUT [0:3] = '{10'h354, 10'h0ab, 10'h154, 10'h2ab};

  localparam logic [9:0] TERC4_QOUT [0:15] = '{
    10'h29c, 10'h263, 10'h2e4, 10'h2e2, 10'h171, 10'h11e, 10'h18e, 10'h13c,
    10'h2cc, 10'h139, 10'h19c, 10'h2c6, 10'h28e, 10'h271, 10'h163, 10'h2c3
  };

  localparam logic [9:0] GUARD_QOUT_BR = 10'h2cc;
  localparam logic [9:0] GUARD_QOUT_G  = 10'h133;

  function automatic logic [9:0] bitrev10(input logic [9:0] v);
    logic [9:0] r;
    r = '0;
    for (int unsigned k = 0; k < 10; k++) r[k] = v[9-k];
    return r;
  endfunction

endpackage

// File: rtl/tmdsencode_if.sv
// Per-pixel symbol request into one TMDS channel encoder.
interface tmdsencode_if;
  logic [1:0] mode;
  logic [1:0] ctl;
  logic [3:0] aux;
  logic [7:0] pix;

  modport master (output mode, ctl, aux, pix);
  modport slave  (input  mode, ctl, aux, pix);
endinterface

// File: rtl/tmds_qm.sv
// Transition-minimisation stage: pixel byte D to q_m[8:0] (q_m[8] = 1 on the XOR path).
module tmds_qm (
  input  logic [7:0] d,
  output logic [8:0] q_m
);
  logic [3:0] n1;
  logic       use_xnor;
  logic [7:0] acc;

  always_comb begin
    n1 = '0;
    for (int unsigned k = 0; k < 8; k++) n1 = n1 + {3'b000, d[k]};
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    acc = '0;
    acc[0] = d[0];
    for (int unsigned i = 1; i < 8; i++)
      acc[i] = use_xnor ? ~(acc[i-1] ^ d[i]) : (acc[i-1] ^ d[i]);
    q_m = {~use_xnor, acc};
  end
endmodule

// File: rtl/tmdsencode.sv
// TMDS channel encoder: 2-stage pipeline (q_m, then DC-balanced / table 10-bit word).
// Optional TMDSENCODE_DISPARITY_EN exposes the running disparity and compiles in its properties.
module tmdsencode
  import tmds_pkg::*;
#(
  parameter int unsigned CHANNEL = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  tmdsencode_if.slave       req,
  output logic [9:0]        o_word
`ifdef TMDSENCODE_DISPARITY_EN
  ,
  output logic signed [4:0] o_disparity
`endif
);

  localparam logic [9:0] GUARD_Q = (CHANNEL == 1) ? GUARD_QOUT_G : GUARD_QOUT_BR;

  tmds_mode_e s1_mode;
  logic [1:0] s1_ctl;
  logic [3:0] s1_aux;
  logic [8:0] s1_qm;
  logic [8:0] qm_comb;

  logic [9:0] q_out, q_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [3:0] n1;
  logic [5:0] diff, cnt6, sum6;
  logic       qm8;

  tmds_qm u_qm (
    .d   (req.pix),
    .q_m (qm_comb)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_mode <= MODE_CTL;
      s1_ctl  <= '0;
      s1_aux  <= '0;
      s1_qm   <= '0;
    end else begin
      s1_mode <= tmds_mode_e'(req.mode);
      s1_ctl  <= req.ctl;
      s1_aux  <= req.aux;
      s1_qm   <= qm_comb;
    end
  end

  // diff = n1 - n0 of q_m[7:0] = 2*n1 - 8; all disparity arithmetic is 6-bit modular, then truncated
  always_comb begin
    n1 = '0;
    for (int unsigned k = 0; k < 8; k++) n1 = n1 + {3'b000, s1_qm[k]};
    qm8     = s1_qm[8];
    diff    = {1'b0, n1, 1'b0} - 6'd8;
    cnt6    = {cnt[4], cnt};
    sum6    = '0;
    q_nxt   = CTL_QOUT[s1_ctl];
    cnt_nxt = '0;
    unique case (s1_mode)
      MODE_VIDEO: begin
        if ((cnt == '0) || (n1 == 4'd4)) begin
          q_nxt = {~qm8, qm8, (qm8 ? s1_qm[7:0] : ~s1_qm[7:0])};
          sum6  = cnt6 + (qm8 ? diff : (6'd0 - diff));
        end else if ((!cnt[4] && (n1 > 4'd4)) || (cnt[4] && (n1 < 4'd4))) begin
          q_nxt = {1'b1, qm8, ~s1_qm[7:0]};
          sum6  = cnt6 + (qm8 ? 6'd2 : 6'd0) - diff;
        end else begin
          q_nxt = {1'b0, qm8, s1_qm[7:0]};
          sum6  = cnt6 + diff - (qm8 ? 6'd0 : 6'd2);
        end
        cnt_nxt = sum6[4:0];
      end
      MODE_DATA:  q_nxt = TERC4_QOUT[s1_aux];
      MODE_GUARD: q_nxt = GUARD_Q;
      default:    q_nxt = CTL_QOUT[s1_ctl];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q_out <= CTL_QOUT[0];
      cnt   <= '0;
    end else begin
      q_out <= q_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign o_word = bitrev10(q_out);

`ifdef TMDSENCODE_DISPARITY_EN
  tmds_mode_e s2_mode;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) s2_mode <= MODE_CTL;
    else            s2_mode <= s1_mode;
  end

  assign o_disparity = cnt;

  a_cnt_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    ($signed(cnt) <= 5'sd10) && ($signed(cnt) >= -5'sd10));
  a_cnt_even: assert property (@(posedge i_clk) disable iff (!i_reset_n) !cnt[0]);
  a_cnt_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (s2_mode != MODE_VIDEO) |-> (cnt == '0));
`endif

endmodule
